// File: rtl/collision_job_scheduler.sv
// Job queue + single-search sequencer for the collision searcher array.
// Optional SCHED_STATS_EN adds saturating job/timeout counters.
//
// state    | meaning
// IDLE     | waiting for a queued job; pops the head when one is present
// ISSUE    | srch_start pulse, timer cleared
// RUN      | search in progress, timer counting toward TIMEOUT
// ABORT    | srch_abort pulse after a timeout
// DRAIN    | one cycle for the searchers to self-reset
// REPORT   | result record held until res_ready
module collision_job_scheduler #(
  parameter int DEPTH_LOG2 = 2,
  parameter int ID_W       = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [4:0]            job_target,
  input  logic [ID_W-1:0]       job_id,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   queue_level,
  output logic                  srch_start,
  output logic [4:0]            srch_target,
  output logic                  srch_abort,
  input  logic                  srch_done,
  input  logic [31:0]           srch_result,
  input  logic [31:0]           srch_digests,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic                  res_found,
  output logic [31:0]           res_counter,
  output logic [31:0]           res_digests
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]           stat_jobs,
  output logic [31:0]           stat_timeouts
`endif
);

  localparam int                DEPTH   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [31:0]       TO_LAST = 32'(TIMEOUT - 1);
  localparam bit                TO_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RUN, S_ABORT, S_DRAIN, S_REPORT
  } state_t;

  state_t                  state_q, state_d;
  logic [4:0]              mem_tgt_q [DEPTH];
  logic [4:0]              mem_tgt_d [DEPTH];
  logic [ID_W-1:0]         mem_id_q  [DEPTH];
  logic [ID_W-1:0]         mem_id_d  [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [ID_W-1:0]         cur_id_q, cur_id_d;
  logic [31:0]             timer_q, timer_d;
  logic                    srch_start_q, srch_start_d;
  logic [4:0]              srch_target_q, srch_target_d;
  logic                    srch_abort_q, srch_abort_d;
  logic                    res_valid_q, res_valid_d;
  logic [ID_W-1:0]         res_id_q, res_id_d;
  logic                    res_found_q, res_found_d;
  logic [31:0]             res_counter_q, res_counter_d;
  logic [31:0]             res_digests_q, res_digests_d;
  logic [31:0]             stat_jobs_q, stat_jobs_d;
  logic [31:0]             stat_timeouts_q, stat_timeouts_d;
  logic                    push, pop;

  assign job_ready   = (level_q != FULL);
  assign queue_level = level_q;
  assign busy        = (state_q != S_IDLE) || (level_q != '0);
  assign srch_start  = srch_start_q;
  assign srch_target = srch_target_q;
  assign srch_abort  = srch_abort_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_found   = res_found_q;
  assign res_counter = res_counter_q;
  assign res_digests = res_digests_q;
`ifdef SCHED_STATS_EN
  assign stat_jobs     = stat_jobs_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

  always_comb begin
    state_d         = state_q;
    mem_tgt_d       = mem_tgt_q;
    mem_id_d        = mem_id_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    cur_id_d        = cur_id_q;
    timer_d         = timer_q;
    srch_start_d    = 1'b0;
    srch_target_d   = srch_target_q;
    srch_abort_d    = 1'b0;
    res_valid_d     = res_valid_q;
    res_id_d        = res_id_q;
    res_found_d     = res_found_q;
    res_counter_d   = res_counter_q;
    res_digests_d   = res_digests_q;
    stat_jobs_d     = stat_jobs_q;
    stat_timeouts_d = stat_timeouts_q;
    push            = job_valid && job_ready;
    pop             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop           = 1'b1;
          cur_id_d      = mem_id_q[rd_ptr_q];
          srch_target_d = mem_tgt_q[rd_ptr_q];
          srch_start_d  = 1'b1;
          timer_d       = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 32'd1;
        // done has priority over a timeout landing in the same cycle
        if (srch_done) begin
          res_counter_d = srch_result;
          res_digests_d = srch_digests;
          res_found_d   = 1'b1;
          state_d       = S_DRAIN;
        end else if (TO_EN && (timer_q == TO_LAST)) begin
          res_counter_d = '0;
          res_digests_d = srch_digests;
          res_found_d   = 1'b0;
          srch_abort_d  = 1'b1;
          state_d       = S_ABORT;
          if (stat_timeouts_q != '1) stat_timeouts_d = stat_timeouts_q + 32'd1;
        end
      end
      S_ABORT: state_d = S_DRAIN;
      S_DRAIN: begin
        res_valid_d = 1'b1;
        res_id_d    = cur_id_q;
        state_d     = S_REPORT;
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (stat_jobs_q != '1) stat_jobs_d = stat_jobs_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_tgt_d[wr_ptr_q] = job_target;
      mem_id_d[wr_ptr_q]  = job_id;
      wr_ptr_d            = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      mem_tgt_q       <= '{default: '0};
      mem_id_q        <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      cur_id_q        <= '0;
      timer_q         <= '0;
      srch_start_q    <= 1'b0;
      srch_target_q   <= '0;
      srch_abort_q    <= 1'b0;
      res_valid_q     <= 1'b0;
      res_id_q        <= '0;
      res_found_q     <= 1'b0;
      res_counter_q   <= '0;
      res_digests_q   <= '0;
      stat_jobs_q     <= '0;
      stat_timeouts_q <= '0;
    end else begin
      state_q         <= state_d;
      mem_tgt_q       <= mem_tgt_d;
      mem_id_q        <= mem_id_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      cur_id_q        <= cur_id_d;
      timer_q         <= timer_d;
      srch_start_q    <= srch_start_d;
      srch_target_q   <= srch_target_d;
      srch_abort_q    <= srch_abort_d;
      res_valid_q     <= res_valid_d;
      res_id_q        <= res_id_d;
      res_found_q     <= res_found_d;
      res_counter_q   <= res_counter_d;
      res_digests_q   <= res_digests_d;
      stat_jobs_q     <= stat_jobs_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

`ifndef SCHED_STATS_EN
  logic unused_stats;
  assign unused_stats = ^{stat_jobs_q, stat_timeouts_q};
`endif

endmodule

// File: doc/collision_job_scheduler.md
Name: collision_job_scheduler

Overview:
- Sequences the collision-search datapath: queues search jobs (target + job ID), issues one search at a time, supervises it with a timeout, and returns one result record per job.
- Sits between the Nios II custom-instruction front end and the searcher array, so software can post several targets and collect results without polling per job.
- Jobs are strictly first-in, first-out: issued in order and reported in order.

Parameters:
- DEPTH_LOG2, 2: job queue holds 2**DEPTH_LOG2 entries.
- ID_W, 4: job ID width.
- TIMEOUT, 1024: maximum RUN cycles per job. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  job offer.
- job_ready  out  1  queue can accept a job.
- job_target  in  5  target bit count for the job.
- job_id  in  ID_W  software tag, returned with the result.
- busy  out  1  state is not IDLE, or the queue is non-empty.
- queue_level  out  DEPTH_LOG2+1  number of queued jobs.
- srch_start  out  1  one-cycle start pulse to the searchers.
- srch_target  out  5  target for the current job; held stable through RUN.
- srch_abort  out  1  one-cycle stop pulse to the searchers.
- srch_done  in  1  searcher found a collision.
- srch_result  in  32  winning counter value, valid with srch_done.
- srch_digests  in  32  running digest count from the searchers.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_id  out  ID_W  ID of the reported job.
- res_found  out  1  1 = collision found, 0 = timed out.
- res_counter  out  32  collision counter; 0 if timed out.
- res_digests  out  32  srch_digests sampled at done or timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; queue is emptied.
  - All registered outputs are 0.
  - job_ready=1, because it is combinational from the queue level.
  - No srch_abort is issued on reset; the searchers share the same reset.
- Queue:
  - Push on job_valid & job_ready.
  - job_ready = (queue_level != 2**DEPTH_LOG2), computed from the registered level. When full, no push is accepted even in a cycle that also pops.
  - Pop and push in the same cycle leave the level unchanged.
  - Read and write pointers wrap modulo the depth.
- FSM states: IDLE, ISSUE, RUN, ABORT, DRAIN, REPORT.
  - IDLE: if queue_level>0, pop the head job into the current-job registers, then go to ISSUE.
  - ISSUE: srch_start=1 for exactly this cycle; srch_target = job target; timer cleared; next state RUN.
  - RUN: timer increments each cycle.
    - On srch_done: capture srch_result and srch_digests, set found=1, go to DRAIN.
    - Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1: capture srch_digests, set counter=0 and found=0, go to ABORT.
    - If srch_done and timeout occur in the same cycle, done wins.
  - ABORT: srch_abort=1 for exactly one cycle; next state DRAIN.
  - DRAIN: one idle cycle so the searchers finish their self-reset; next state REPORT.
  - REPORT: res_valid=1 and all res_* outputs held stable until res_ready. On the handshake, go to IDLE, with res_valid deasserting on the next cycle.
- srch_done outside RUN is ignored.
- Latency:
  - A job accepted at clock edge t into an empty queue with the FSM in IDLE gives srch_start=1 in cycle t+2.
  - After srch_done is seen in RUN, res_valid rises 2 cycles later.
- Reset asserted mid-job: the job is dropped and no result is produced.
- The timer is 32 bits wide and does not wrap before TIMEOUT is reached.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: adds output ports stat_jobs (32) and stat_timeouts (32), both reset to 0.
  - stat_jobs increments on each REPORT handshake.
  - stat_timeouts increments on each entry to ABORT.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic job: push id=3, target=5. The searcher model raises done 10 cycles after start with result=0x1234 and digests=10. Required: exactly one srch_start pulse with srch_target=5, then res_valid with id=3, found=1, counter=0x1234, digests=10.
- Full queue: with a result stalled, push 5 jobs (ids 1..5), DEPTH_LOG2=2. Required: job_ready=0 once queue_level=4, so the 5th job is held. After draining, results appear in id order 1,2,3,4, then 5.
- Timeout: TIMEOUT=16, searcher never signals done. Required: srch_abort pulses once, the cycle after the 16th RUN cycle; result has found=0, counter=0.
- Simultaneous events: TIMEOUT=16 with srch_done asserted on the 16th RUN cycle. Required: found=1, and srch_abort is never asserted.
- Backpressure and reset: hold res_ready=0 for 20 cycles. Required: res_* outputs stable and no new srch_start. Then assert reset during a RUN. Required: all outputs 0, queue_level=0, job_ready=1, no res_valid after release.
- Stats (SCHED_STATS_EN defined): run 3 jobs, one of which times out. Required: stat_jobs=3, stat_timeouts=1.
